md_controller: RTL and testbench

MD_CONTROLLER -- requirements
Module: md_controller

---
 rtl/md_controller.sv | 152 +++++++++++++++
 tb/tb_md_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/md_controller.sv
// Iterative multiply/divide unit with HI/LO registers: 32 radix-2 steps plus one
// fix-up cycle, with pipeline stall and flush handling for the EX stage.
module md_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        EX_start,
    input  logic [1:0]  EX_md_op,
    input  logic [31:0] EX_Qa,
    input  logic [31:0] EX_Qb,
    input  logic        EX_mf,
    input  logic        EX_mf_sel,
    input  logic        EX_mt,
    input  logic        EX_mt_sel,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_Result,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // state | meaning:  IDLE accept start / mt | RUN 32 radix-2 steps | FIX sign fix-up + HI/LO write
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, d_q;
    logic [63:0] p_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        signed_in;
    logic [31:0] abs_a, abs_b;
    logic        is_div, signed_op;
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] step_d;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] hi_fix, lo_fix;

    assign signed_in = ~EX_md_op[0];
    assign abs_a     = (signed_in && EX_Qa[31]) ? (~EX_Qa + 32'd1) : EX_Qa;
    assign abs_b     = (signed_in && EX_Qb[31]) ? (~EX_Qb + 32'd1) : EX_Qb;

    assign is_div    = op_q[1];
    assign signed_op = ~op_q[0];

    // Multiply: p_q = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide:   p_q = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, d_q} : 33'd0);
    assign div_ge   = p_q[63:31] >= {1'b0, d_q};
    assign div_diff = p_q[62:31] - d_q;

    always_comb begin
        step_d = {mul_sum, p_q[31:1]};
        if (is_div) begin
            if (div_ge)
                step_d = {div_diff, p_q[30:0], 1'b1};
            else
                step_d = {p_q[62:0], 1'b0};
        end
    end

    assign prod_fix = (signed_op && (a_q[31] ^ b_q[31])) ? (~p_q + 64'd1) : p_q;
    assign quo_fix  = (signed_op && (a_q[31] ^ b_q[31])) ? (~p_q[31:0] + 32'd1) : p_q[31:0];
    assign rem_fix  = (signed_op && a_q[31]) ? (~p_q[63:32] + 32'd1) : p_q[63:32];

    always_comb begin
        hi_fix = prod_fix[63:32];
        lo_fix = prod_fix[31:0];
        if (is_div) begin
            if (b_q == 32'd0) begin
                hi_fix = a_q;
                lo_fix = 32'hFFFF_FFFF;
            end else begin
                hi_fix = rem_fix;
                lo_fix = quo_fix;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            d_q     <= 32'd0;
            p_q     <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (EX_start && !flush) begin
                        op_q    <= EX_md_op;
                        a_q     <= EX_Qa;
                        b_q     <= EX_Qb;
                        cnt_q   <= 6'd0;
                        state_q <= RUN;
                        if (EX_md_op[1]) begin
                            p_q <= {32'd0, abs_a};
                            d_q <= abs_b;
                        end else begin
                            p_q <= {32'd0, abs_b};
                            d_q <= abs_a;
                        end
                    end else if (EX_mt) begin
                        if (EX_mt_sel)
                            hi_q <= EX_Qa;
                        else
                            lo_q <= EX_Qa;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        p_q   <= step_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31)
                            state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    if (!flush) begin
                        hi_q   <= hi_fix;
                        lo_q   <= lo_fix;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign stall     = busy && (EX_start || EX_mf || EX_mt);
    assign md_Result = EX_mf_sel ? hi_q : lo_q;
    assign done      = done_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_md_controller.sv
// Directed bench for md_controller: arithmetic results, cycle timing, stall,
// flush, mt/mf access, reset abort and back-to-back issue.
module tb_md_controller;

    logic        clock;
    logic        reset;
    logic        EX_start;
    logic [1:0]  EX_md_op;
    logic [31:0] EX_Qa, EX_Qb;
    logic        EX_mf, EX_mf_sel, EX_mt, EX_mt_sel;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] md_Result, HI, LO;

    int total = 0;
    int bad   = 0;

    md_controller dut (
        .clock     (clock),
        .reset     (reset),
        .EX_start  (EX_start),
        .EX_md_op  (EX_md_op),
        .EX_Qa     (EX_Qa),
        .EX_Qb     (EX_Qb),
        .EX_mf     (EX_mf),
        .EX_mf_sel (EX_mf_sel),
        .EX_mt     (EX_mt),
        .EX_mt_sel (EX_mt_sel),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .md_Result (md_Result),
        .done      (done),
        .HI        (HI),
        .LO        (LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen at the next rising edge (E0).
    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        EX_start = 1'b1;
        EX_md_op = op;
        EX_Qa    = a;
        EX_Qb    = b;
        @(negedge clock);
        EX_start = 1'b0;
        chk({tag, " busy_after_E0"}, 64'(busy), 64'd1);
    endtask

    // Returns on the negedge of the done cycle.
    task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el);
        int n;
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clock);
            if (busy === 1'b1) n++;
        end
        chk({tag, " busy_cycles"}, 64'(n), 64'd33);
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " HI"}, 64'(HI), 64'(eh));
        chk({tag, " LO"}, 64'(LO), 64'(el));
    endtask

    initial begin
        logic stall_ok;
        int   n;

        reset = 1'b0;
        EX_start = 1'b0; EX_md_op = 2'b00; EX_Qa = 32'd0; EX_Qb = 32'd0;
        EX_mf = 1'b0; EX_mf_sel = 1'b0; EX_mt = 1'b0; EX_mt_sel = 1'b0; flush = 1'b0;

        #3;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst HI", 64'(HI), 64'd0);
        chk("rst LO", 64'(LO), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // signed multiply, negative result
        issue("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        @(negedge clock);
        chk("mult_neg done_one_cycle", 64'(done), 64'd0);
        EX_mf_sel = 1'b1; #1;
        chk("mf HI", 64'(md_Result), 64'hFFFF_FFFF);
        EX_mf_sel = 1'b0; #1;
        chk("mf LO", 64'(md_Result), 64'hFFFF_FFFA);

        issue("divu", 2'b11, 32'd100, 32'd7);
        wait_done("divu", 32'd2, 32'd14);
        @(negedge clock);
        issue("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clock);
        issue("div0", 2'b10, 32'd5, 32'd0);
        wait_done("div0", 32'd5, 32'hFFFF_FFFF);
        @(negedge clock);
        issue("divu0", 2'b11, 32'h8000_0001, 32'd0);
        wait_done("divu0", 32'h8000_0001, 32'hFFFF_FFFF);
        @(negedge clock);
        issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'd0, 32'h8000_0000);
        @(negedge clock);
        issue("div_negrem", 2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_negrem", 32'd1, 32'hFFFF_FFFD);
        @(negedge clock);
        issue("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_min", 32'h4000_0000, 32'd0);
        @(negedge clock);
        issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clock);

        // mf asserted at cycle 5 of a multu: stall until IDLE
        issue("mf_stall", 2'b01, 32'h0001_0000, 32'h0003_0000);
        repeat (4) @(negedge clock);
        EX_mf = 1'b1; EX_mf_sel = 1'b1; #1;
        chk("mf_stall stall_on", 64'(stall), 64'd1);
        stall_ok = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clock);
            #1;
            if (busy === 1'b1 && stall !== 1'b1) stall_ok = 1'b0;
            n++;
        end
        chk("mf_stall stall_held", 64'(stall_ok), 64'd1);
        chk("mf_stall busy_released", 64'(busy), 64'd0);
        chk("mf_stall stall_idle", 64'(stall), 64'd0);
        chk("mf_stall result", 64'(md_Result), 64'd3);
        EX_mf = 1'b0; EX_mf_sel = 1'b0;
        @(negedge clock);

        // mt into HI and LO; stall stays low in IDLE
        EX_mt = 1'b1; EX_mt_sel = 1'b1; EX_Qa = 32'h1234_5678; #1;
        chk("mt stall_idle", 64'(stall), 64'd0);
        @(negedge clock);
        EX_mt_sel = 1'b0;
        EX_mf_sel = 1'b1; #1;
        chk("mt HI", 64'(md_Result), 64'h1234_5678);
        @(negedge clock);
        EX_mt = 1'b0; EX_mf_sel = 1'b0; #1;
        chk("mt LO", 64'(md_Result), 64'h1234_5678);

        // flush at RUN cycle 10
        issue("flush", 2'b01, 32'd7, 32'd9);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush done", 64'(done), 64'd0);
        chk("flush HI", 64'(HI), 64'h1234_5678);
        chk("flush LO", 64'(LO), 64'h1234_5678);
        @(negedge clock);
        chk("flush done_later", 64'(done), 64'd0);

        // flush in IDLE blocks start
        EX_start = 1'b1; EX_md_op = 2'b01; EX_Qa = 32'd2; EX_Qb = 32'd3; flush = 1'b1;
        @(negedge clock);
        EX_start = 1'b0; flush = 1'b0;
        chk("idle_flush busy", 64'(busy), 64'd0);

        // start and mt together: start wins
        EX_mt = 1'b1; EX_mt_sel = 1'b0;
        issue("start_mt", 2'b01, 32'd2, 32'd3);
        EX_mt = 1'b0;
        chk("start_mt LO_kept", 64'(LO), 64'h1234_5678);
        wait_done("start_mt", 32'd0, 32'd6);
        @(negedge clock);

        // reset at RUN cycle 20
        issue("rst_run", 2'b01, 32'd5, 32'd6);
        repeat (19) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rst_run busy", 64'(busy), 64'd0);
        chk("rst_run HI", 64'(HI), 64'd0);
        chk("rst_run LO", 64'(LO), 64'd0);
        chk("rst_run done", 64'(done), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        issue("after_rst", 2'b01, 32'd3, 32'd4);
        wait_done("after_rst", 32'd0, 32'd12);
        @(negedge clock);

        // back-to-back: divu issued on the done cycle of a mult
        issue("b2b_mult", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done("b2b_mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue("b2b_divu", 2'b11, 32'd100, 32'd7);
        chk("b2b_divu done_dropped", 64'(done), 64'd0);
        wait_done("b2b_divu", 32'd2, 32'd14);
        @(negedge clock);
        chk("b2b_divu done_one_cycle", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
